solver_dispatcher: RTL and testbench

- Initiator-side front end for the endgame solver `pipeline`. Accepts one board job at a time from a host over a valid/ready handshake.
- Drives the solver's `enable`/`iPlayer`/`iOpponent` inputs and waits for `solved`. Captures `res` together with the job tag and elapsed cycles, and returns them over a second valid/ready handshake.
- Replaces the hand-written stimulus loop; sits between a host/UART job queue and the solver core.

---
 rtl/othello_pkg.sv | 16 +
 rtl/job_cycle_counter.sv | 32 +++
 rtl/solver_dispatcher.sv | 144 ++++++++++++++
 tb/tb_solver_dispatcher.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/othello_pkg.sv
// Shared types and defaults for the endgame solver front end.
package othello_pkg;

  typedef logic [63:0]        bitboard_t;
  typedef logic signed [7:0]  score_t;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    RUN,
    RESP
  } dispatch_state_t;

  localparam logic [31:0] SOLVER_TIMEOUT_DEFAULT = 32'd10_000_000;

endpackage

// File: rtl/job_cycle_counter.sv
// Saturating cycle counter with synchronous clear and enable; at_limit flags that the
// cycle in progress completes LIMIT counts.
module job_cycle_counter
  import othello_pkg::*;
#(
  parameter int               CYC_W = 32,
  parameter logic [CYC_W-1:0] LIMIT = '1
) (
  input  logic             iCLOCK,
  input  logic             iRESET_N,
  input  logic             clr,
  input  logic             en,
  output logic [CYC_W-1:0] count,
  output logic             at_limit
);

  logic [CYC_W-1:0] count_inc;

  assign count_inc = (&count) ? count : count + CYC_W'(1);
  assign at_limit  = (count_inc == LIMIT);

  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/solver_dispatcher.sv
// One-job-at-a-time front end for the endgame solver: enable rises RESTART_GAP+1 cycles after accept,
// result is valid 1 cycle after solved and held until iResReady. SOLVER_DISPATCH_TIMEOUT_EN adds a RUN limit.
module solver_dispatcher
  import othello_pkg::*;
#(
  parameter int          TAG_W       = 8,
  parameter int          RESTART_GAP = 2,
  parameter int          CYC_W       = 32,
  parameter logic [31:0] TIMEOUT_CYC = SOLVER_TIMEOUT_DEFAULT
) (
  input  logic              iCLOCK,
  input  logic              iRESET_N,
  input  logic              iJobValid,
  output logic              oJobReady,
  input  logic [63:0]       iJobPlayer,
  input  logic [63:0]       iJobOpponent,
  input  logic [TAG_W-1:0]  iJobTag,
  output logic              oEnable,
  output logic [63:0]       oPlayer,
  output logic [63:0]       oOpponent,
  input  logic              iSolved,
  input  logic signed [7:0] iRes,
  output logic              oResValid,
  input  logic              iResReady,
  output logic signed [7:0] oRes,
  output logic [TAG_W-1:0]  oResTag,
  output logic [CYC_W-1:0]  oResCycles,
  output logic              oResBad,
  output logic              oResTimeout
);

  localparam int               GAP_W    = (RESTART_GAP > 2) ? $clog2(RESTART_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(RESTART_GAP - 1);

  dispatch_state_t  state;
  logic [GAP_W-1:0] gap_cnt;
  bitboard_t        overlap;
  logic             cnt_clr;
  logic             cnt_en;
  logic             at_limit;
  logic             timeout_hit;
  logic [CYC_W-1:0] cnt_val;
  logic [CYC_W-1:0] run_cycles;

  assign oJobReady = (state == IDLE);
  assign overlap   = iJobPlayer & iJobOpponent;
  assign cnt_clr   = (state == GAP) && (gap_cnt == '0);
  assign cnt_en    = (state == RUN);
  // Cycle count including the RUN cycle currently in progress.
  assign run_cycles = (&cnt_val) ? cnt_val : cnt_val + CYC_W'(1);

  job_cycle_counter #(
    .CYC_W (CYC_W),
    .LIMIT (CYC_W'(TIMEOUT_CYC))
  ) u_cycles (
    .iCLOCK   (iCLOCK),
    .iRESET_N (iRESET_N),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .count    (cnt_val),
    .at_limit (at_limit)
  );

`ifdef SOLVER_DISPATCH_TIMEOUT_EN
  assign timeout_hit = at_limit;
`else
  logic unused_limit;
  assign unused_limit = at_limit;
  assign timeout_hit  = 1'b0;
`endif

  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      oEnable     <= 1'b0;
      oPlayer     <= '0;
      oOpponent   <= '0;
      oResValid   <= 1'b0;
      oRes        <= '0;
      oResTag     <= '0;
      oResCycles  <= '0;
      oResBad     <= 1'b0;
      oResTimeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iJobValid) begin
            oPlayer   <= iJobPlayer;
            oOpponent <= iJobOpponent;
            oResTag   <= iJobTag;
            if (overlap != '0) begin
              state       <= RESP;
              oResValid   <= 1'b1;
              oResBad     <= 1'b1;
              oRes        <= '0;
              oResCycles  <= '0;
              oResTimeout <= 1'b0;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_INIT;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state   <= RUN;
            oEnable <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        RUN: begin
          // A solve in the limit cycle takes precedence over the timeout.
          if (iSolved) begin
            state       <= RESP;
            oEnable     <= 1'b0;
            oResValid   <= 1'b1;
            oRes        <= iRes;
            oResCycles  <= run_cycles;
            oResBad     <= 1'b0;
            oResTimeout <= 1'b0;
          end else if (timeout_hit) begin
            state       <= RESP;
            oEnable     <= 1'b0;
            oResValid   <= 1'b1;
            oRes        <= '0;
            oResCycles  <= run_cycles;
            oResBad     <= 1'b0;
            oResTimeout <= 1'b1;
          end
        end
        RESP: begin
          if (iResReady) begin
            state     <= IDLE;
            oResValid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_solver_dispatcher.sv
// Scoreboard bench for solver_dispatcher: host driver, behavioural solver, result consumer and monitor.
module tb_solver_dispatcher;

  localparam int RG = 2;
  localparam int TO = 50;
`ifdef SOLVER_DISPATCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic signed [7:0] res;
    logic [7:0]        tag;
    logic [31:0]       cyc;
    logic              bad;
    logic              to;
  } res_t;

  typedef struct {
    int                lat;
    logic signed [7:0] res;
    bit                stale;
  } cfg_t;

  logic              iCLOCK = 1'b0;
  logic              iRESET_N;
  logic              iJobValid;
  logic              oJobReady;
  logic [63:0]       iJobPlayer;
  logic [63:0]       iJobOpponent;
  logic [7:0]        iJobTag;
  logic              oEnable;
  logic [63:0]       oPlayer;
  logic [63:0]       oOpponent;
  logic              iSolved;
  logic signed [7:0] iRes;
  logic              oResValid;
  logic              iResReady;
  logic signed [7:0] oRes;
  logic [7:0]        oResTag;
  logic [31:0]       oResCycles;
  logic              oResBad;
  logic              oResTimeout;

  solver_dispatcher #(
    .TAG_W       (8),
    .RESTART_GAP (RG),
    .CYC_W       (32),
    .TIMEOUT_CYC (32'(TO))
  ) dut (
    .iCLOCK       (iCLOCK),
    .iRESET_N     (iRESET_N),
    .iJobValid    (iJobValid),
    .oJobReady    (oJobReady),
    .iJobPlayer   (iJobPlayer),
    .iJobOpponent (iJobOpponent),
    .iJobTag      (iJobTag),
    .oEnable      (oEnable),
    .oPlayer      (oPlayer),
    .oOpponent    (oOpponent),
    .iSolved      (iSolved),
    .iRes         (iRes),
    .oResValid    (oResValid),
    .iResReady    (iResReady),
    .oRes         (oRes),
    .oResTag      (oResTag),
    .oResCycles   (oResCycles),
    .oResBad      (oResBad),
    .oResTimeout  (oResTimeout)
  );

  always #5 iCLOCK = ~iCLOCK;

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t exp_q[$];
  cfg_t cfg_q[$];
  int   rdy_q[$];
  bit   in_flight = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected outcome of a job, derived from the board rule, solve latency and timeout limit.
  task automatic issue(input logic [63:0] p, input logic [63:0] o, input logic [7:0] tag,
                       input int lat, input logic signed [7:0] res, input bit stale, input int rdelay);
    res_t e;
    cfg_t c;
    bit   bad;
    int   n;
    bad = ((p & o) != 64'd0);
    e.tag = tag;
    e.bad = bad;
    if (bad) begin
      e.res = 0; e.cyc = 0; e.to = 1'b0;
    end else if (TO_EN && (lat == 0 || lat > TO)) begin
      e.res = 0; e.cyc = 32'(TO); e.to = 1'b1;
    end else begin
      e.res = res; e.cyc = 32'(lat); e.to = 1'b0;
    end
    exp_q.push_back(e);
    rdy_q.push_back(rdelay);
    if (!bad) begin
      c.lat = lat; c.res = res; c.stale = stale;
      cfg_q.push_back(c);
    end
    @(posedge iCLOCK); #1;
    iJobValid = 1'b1; iJobPlayer = p; iJobOpponent = o; iJobTag = tag;
    n = 0;
    forever begin
      @(negedge iCLOCK);
      if (oJobReady) break;
      n++;
      if (n > 3000) begin
        chk(1'b0, "accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge iCLOCK); #1;
    iJobValid = 1'b0;
    iJobPlayer = {$urandom, $urandom}; iJobOpponent = {$urandom, $urandom}; iJobTag = 8'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_flight) && n < 5000) begin
      @(negedge iCLOCK);
      n++;
    end
    chk(n < 5000, "drain_timeout", 64'(exp_q.size()), 0);
  endtask

  // Behavioural solver: raises solved in its lat-th enabled cycle; stale jobs keep solved high until re-enabled.
  initial begin : solver
    cfg_t cur;
    int   en_cnt;
    bit   active;
    cur = '{lat: 0, res: 0, stale: 1'b0};
    en_cnt = 0; active = 1'b0;
    iSolved = 1'b0; iRes = 0;
    forever begin
      @(posedge iCLOCK); #1;
      if (!iRESET_N) begin
        iSolved = 1'b0; en_cnt = 0; active = 1'b0;
        cur = '{lat: 0, res: 0, stale: 1'b0};
        continue;
      end
      if (oEnable) begin
        if (!active) begin
          active = 1'b1; en_cnt = 0;
          if (cfg_q.size() != 0) cur = cfg_q.pop_front();
          else cur = '{lat: 0, res: 0, stale: 1'b0};
        end
        en_cnt++;
        if (cur.lat != 0 && en_cnt == cur.lat) begin
          iSolved = 1'b1; iRes = cur.res;
        end else begin
          iSolved = 1'b0; iRes = 8'($urandom);
        end
      end else begin
        active = 1'b0;
        if (!(cur.stale && iSolved)) begin
          iSolved = 1'b0; iRes = 8'($urandom);
        end
      end
    end
  end

  initial begin : consumer
    int wait_cnt;
    wait_cnt = -1;
    iResReady = 1'b0;
    forever begin
      @(posedge iCLOCK); #1;
      if (!iRESET_N) begin
        iResReady = 1'b0; wait_cnt = -1;
      end else if (iResReady) begin
        iResReady = 1'b0; wait_cnt = -1;
      end else if (oResValid) begin
        if (wait_cnt < 0) wait_cnt = (rdy_q.size() != 0) ? rdy_q.pop_front() : 0;
        if (wait_cnt == 0) iResReady = 1'b1;
        else wait_cnt--;
      end
    end
  end

  res_t        m_obs, m_cur, m_exp;
  bit          m_have = 1'b0, m_wait_en = 1'b0, m_bad = 1'b0;
  int          m_cyc = 0, m_acc = 0, m_en = 0, m_solv = 0;
  logic [63:0] m_p = '0, m_o = '0;

  initial begin : monitor
    forever begin
      @(negedge iCLOCK);
      m_cyc++;
      if (!iRESET_N) begin
        m_have = 1'b0; in_flight = 1'b0; m_wait_en = 1'b0;
        continue;
      end
      m_obs = {oRes, oResTag, oResCycles, oResBad, oResTimeout};
      chk(oJobReady == !in_flight, "job_ready", 64'(oJobReady), 64'(!in_flight));
      if (!in_flight || m_bad) chk(!oEnable, "enable_idle", 64'(oEnable), 0);
      if (oEnable) begin
        if (m_wait_en) begin
          chk(m_cyc - m_acc == RG + 1, "enable_latency", 64'(m_cyc - m_acc), 64'(RG + 1));
          m_wait_en = 1'b0; m_en = m_cyc;
        end
        chk(oPlayer == m_p && oOpponent == m_o, "board_hold", oPlayer ^ oOpponent, m_p ^ m_o);
        if (iSolved) m_solv = m_cyc;
      end
      if (oResValid) begin
        if (!m_have) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "spurious_result", 64'(m_obs), 0);
          end else begin
            m_exp = exp_q.pop_front();
            chk(m_obs == m_exp, "result", 64'(m_obs), 64'(m_exp));
            if (m_exp.bad)     chk(m_cyc == m_acc + 1, "bad_latency", 64'(m_cyc - m_acc), 1);
            else if (m_exp.to) chk(m_cyc == m_en + TO, "timeout_latency", 64'(m_cyc - m_en), 64'(TO));
            else               chk(m_cyc == m_solv + 1, "result_latency", 64'(m_cyc - m_solv), 1);
          end
          m_have = 1'b1; m_cur = m_obs;
        end else begin
          chk(m_obs == m_cur, "result_stable", 64'(m_obs), 64'(m_cur));
        end
        if (iResReady) begin
          m_have = 1'b0; in_flight = 1'b0;
        end
      end
      if (oJobReady && iJobValid) begin
        in_flight = 1'b1; m_acc = m_cyc;
        m_bad = ((iJobPlayer & iJobOpponent) != 64'd0);
        m_p = iJobPlayer; m_o = iJobOpponent;
        m_wait_en = !m_bad;
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [63:0]       p, o;
    logic signed [7:0] r;
    int                n;
    iRESET_N = 1'b1; iJobValid = 1'b0; iJobPlayer = '0; iJobOpponent = '0; iJobTag = '0;
    #2 iRESET_N = 1'b0;
    repeat (3) @(negedge iCLOCK);
    chk({oJobReady, oEnable, oResValid} == 3'b100, "reset_ctrl", {oJobReady, oEnable, oResValid}, 3'b100);
    chk(oPlayer == 0 && oOpponent == 0, "reset_boards", oPlayer | oOpponent, 0);
    chk({oRes, oResTag, oResCycles, oResBad, oResTimeout} == '0, "reset_fields",
        {oRes, oResTag, oResCycles, oResBad, oResTimeout}, 0);
    iRESET_N = 1'b1;

    issue(64'h10B8DDE3B1B98284, 64'h8E45221C4E467C78, 8'h5A, 100, 8'sd16, 1'b0, 0);
    drain();
    issue(64'h1, 64'h3, 8'h11, 5, 8'sd3, 1'b0, 0);
    drain();
    issue(64'h0000_0000_0000_00F0, 64'h0000_0000_0000_0F00, 8'h21, 30, 8'sd14, 1'b0, 5);
    issue(64'h00FF_0000_0000_0000, 64'h0000_FF00_0000_0000, 8'h22, 12, 8'sd2, 1'b0, 0);
    drain();
    issue(64'h0000_0000_8100_0000, 64'h0000_0000_0042_0000, 8'h31, 10, 8'sd7, 1'b1, 0);
    issue(64'h0000_0000_0000_0003, 64'h0000_0000_0000_000C, 8'h32, 20, -8'sd5, 1'b0, 1);
    drain();

    issue(64'h0000_00FF_0000_0000, 64'h0000_0000_00FF_0000, 8'h77, 300, 8'sd9, 1'b0, 0);
    n = 0;
    while (!oEnable && n < 100) begin
      @(negedge iCLOCK);
      n++;
    end
    chk(n < 100, "reset_run_enable", 64'(oEnable), 1);
    repeat (10) @(posedge iCLOCK);
    #3 iRESET_N = 1'b0;
    #1;
    chk(!oEnable, "reset_async_enable", 64'(oEnable), 0);
    chk(!oResValid, "reset_async_valid", 64'(oResValid), 0);
    exp_q.delete(); cfg_q.delete(); rdy_q.delete();
    repeat (3) @(negedge iCLOCK);
    iRESET_N = 1'b1;
    repeat (20) @(negedge iCLOCK);
    chk(oJobReady, "reset_release_ready", 64'(oJobReady), 1);
    chk(!oResValid, "reset_no_stale", 64'(oResValid), 0);

    for (int k = 0; k < 14; k++) begin
      p = {$urandom, $urandom};
      o = {$urandom, $urandom};
      if ($urandom_range(3) != 0) o = o & ~p;
      r = 8'($urandom);
      issue(p, o, 8'(k + 8'h80), int'($urandom_range(1, 40)), r, ($urandom_range(3) == 0),
            int'($urandom_range(0, 3)));
    end
    drain();

`ifdef SOLVER_DISPATCH_TIMEOUT_EN
    issue(64'h0000_0000_0000_1000, 64'h0000_0000_0000_2000, 8'hE1, 0, 8'sd0, 1'b0, 0);
    drain();
    issue(64'h0000_0000_0001_0000, 64'h0000_0000_0002_0000, 8'hE2, TO, -8'sd12, 1'b0, 2);
    drain();
    issue(64'h0000_0000_0100_0000, 64'h0000_0000_0200_0000, 8'hE3, TO - 1, 8'sd40, 1'b0, 0);
    drain();
`endif

    repeat (5) @(negedge iCLOCK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
